// File: rtl/compressor_pwm_driver.sv
// -----------------------------------------------------------------------------
// compressor_pwm_driver
//
// Turns the signed Q8.8 output of the upstream PID controller into a PWM drive
// for the compressor. Negative pid_out is cooling demand. The duty cycle is
// only picked up at PWM period boundaries so the waveform never glitches
// mid-period. When a run ends, a minimum-off lockout keeps the compressor
// from short-cycling.
//
// Optional feature (compile-time macro COMP_SOFTSTART_EN):
//   When defined, a soft-start ramp limits the applied duty. The ramp starts
//   at RAMP_STEP when a run begins and grows by RAMP_STEP every period,
//   saturating at 255. When undefined, no ramp logic exists.
//
// Parameters
//   PRESCALE        clk cycles per PWM tick (>=1)
//   DUTY_SHIFT      right shift from demand magnitude to duty
//   MIN_OFF_PERIODS PWM periods that the drive is held off after a run (>=1)
//   RAMP_STEP       soft-start duty increment per period
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   run request; low stops a run through the lockout
//   pid_out[15:0] in   signed Q8.8 controller output, sampled at boundaries
//   comp_on       out  registered compressor drive
//   duty_applied  out  duty in force this period (0..255)
//   lockout       out  high while the minimum-off lockout is active
//   period_start  out  one-clk pulse on the first clk of each PWM period
// -----------------------------------------------------------------------------
module compressor_pwm_driver #(
  parameter int PRESCALE        = 10,
  parameter int DUTY_SHIFT      = 4,
  parameter int MIN_OFF_PERIODS = 8,
  parameter int RAMP_STEP       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pid_out,
  output logic        comp_on,
  output logic [7:0]  duty_applied,
  output logic        lockout,
  output logic        period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LW = $clog2(MIN_OFF_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_LOCKOUT
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg;
  logic [7:0]      pwm_cnt_reg;
  logic [LW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [7:0]      duty_latched_reg, duty_latched_next;
  logic            comp_on_reg;
  logic            period_start_reg;
  logic            tick;
  logic            pb;
  logic            start_run;
  logic [7:0]      duty_eff;

  // ---------------------------------------------------------------------------
  // Timebase: prescaler -> tick, tick -> 255-step PWM counter.
  // ---------------------------------------------------------------------------
  assign tick = (presc_reg == PW'(PRESCALE - 1));
  // Period boundary: the tick on which pwm_cnt wraps 254 -> 0.
  assign pb   = tick && (pwm_cnt_reg == 8'd254);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg        <= '0;
      pwm_cnt_reg      <= 8'd0;
      period_start_reg <= 1'b0;
    end else begin
      presc_reg        <= tick ? '0 : presc_reg + PW'(1);
      if (tick) begin
        pwm_cnt_reg <= pb ? 8'd0 : pwm_cnt_reg + 8'd1;
      end
      period_start_reg <= pb;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty calculation. Negating in 17 bits keeps -32768 as +32768.
  // ---------------------------------------------------------------------------
  logic signed [16:0] demand;
  logic signed [16:0] demand_shift;
  logic [7:0]         duty_calc;

  assign demand       = -$signed({pid_out[15], pid_out});
  assign demand_shift = demand >>> DUTY_SHIFT;

  always_comb begin
    duty_calc = 8'd0;
    if (demand[16] || (demand == 17'sd0)) begin
      duty_calc = 8'd0;
    end else if (demand_shift > 17'sd255) begin
      duty_calc = 8'd255;
    end else begin
      duty_calc = demand_shift[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Run / lockout state machine.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_OFF;
      lock_cnt_reg     <= '0;
      duty_latched_reg <= 8'd0;
    end else begin
      state_reg        <= state_next;
      lock_cnt_reg     <= lock_cnt_next;
      duty_latched_reg <= duty_latched_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    lock_cnt_next     = lock_cnt_reg;
    duty_latched_next = duty_latched_reg;
    start_run         = 1'b0;
    case (state_reg)
      ST_OFF: begin
        if (pb && enable && (duty_calc != 8'd0)) begin
          state_next        = ST_RUN;
          duty_latched_next = duty_calc;
          start_run         = 1'b1;
        end
      end
      ST_RUN: begin
        // Enable loss stops the run at once, boundary or not.
        if (!enable) begin
          state_next    = ST_LOCKOUT;
          lock_cnt_next = LW'(MIN_OFF_PERIODS);
        end else if (pb) begin
          if (duty_calc == 8'd0) begin
            state_next    = ST_LOCKOUT;
            lock_cnt_next = LW'(MIN_OFF_PERIODS);
          end else begin
            duty_latched_next = duty_calc;
          end
        end
      end
      ST_LOCKOUT: begin
        if (pb) begin
          if (lock_cnt_reg <= LW'(1)) begin
            // Count reaches zero: the OFF decision is taken on this same
            // boundary, so the drive is held off for exactly the lockout
            // periods and a pending demand restarts without a spare period.
            lock_cnt_next = '0;
            if (enable && (duty_calc != 8'd0)) begin
              state_next        = ST_RUN;
              duty_latched_next = duty_calc;
              start_run         = 1'b1;
            end else begin
              state_next = ST_OFF;
            end
          end else begin
            lock_cnt_next = lock_cnt_reg - LW'(1);
          end
        end
      end
      default: begin
        state_next    = ST_OFF;
        lock_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Effective duty (optionally limited by the soft-start ramp).
  // ---------------------------------------------------------------------------
`ifdef COMP_SOFTSTART_EN
  localparam logic [8:0] RAMP_STEP_W = (RAMP_STEP > 255) ? 9'd255 : 9'(RAMP_STEP);

  logic [7:0] ramp_reg, ramp_next;
  logic [8:0] ramp_sum;

  assign ramp_sum = {1'b0, ramp_reg} + RAMP_STEP_W;

  always_comb begin
    ramp_next = ramp_reg;
    if (start_run) begin
      ramp_next = RAMP_STEP_W[7:0];
    end else if (pb && (state_reg == ST_RUN) && (state_next == ST_RUN)) begin
      ramp_next = ramp_sum[8] ? 8'd255 : ramp_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_reg <= 8'd0;
    end else begin
      ramp_reg <= ramp_next;
    end
  end

  assign duty_eff = (duty_latched_reg < ramp_reg) ? duty_latched_reg : ramp_reg;
`else
  assign duty_eff = duty_latched_reg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. comp_on lags pwm_cnt by one clk; the enable term drops it on the
  // very clk that enable is seen low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_on_reg <= 1'b0;
    end else begin
      comp_on_reg <= (state_reg == ST_RUN) && enable && (pwm_cnt_reg < duty_eff);
    end
  end

  assign comp_on      = comp_on_reg;
  assign duty_applied = (state_reg == ST_RUN) ? duty_eff : 8'd0;
  assign lockout      = (state_reg == ST_LOCKOUT);
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_compressor_pwm_driver.sv
// -----------------------------------------------------------------------------
// Testbench for compressor_pwm_driver (PRESCALE=1, DUTY_SHIFT=4,
// MIN_OFF_PERIODS=2, RAMP_STEP=32). A period-level reference model predicts
// per-period on-time, applied duty, lockout and the period_start pulse.
// -----------------------------------------------------------------------------
module tb_compressor_pwm_driver;

  localparam int PRESCALE = 1;
  localparam int SHIFT    = 4;
  localparam int MIN_OFF  = 2;
  localparam int STEP     = 32;
  localparam int PLEN     = 255;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] pid_out;
  logic        comp_on;
  logic [7:0]  duty_applied;
  logic        lockout;
  logic        period_start;

  compressor_pwm_driver #(
    .PRESCALE        (PRESCALE),
    .DUTY_SHIFT      (SHIFT),
    .MIN_OFF_PERIODS (MIN_OFF),
    .RAMP_STEP       (STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pid_out      (pid_out),
    .comp_on      (comp_on),
    .duty_applied (duty_applied),
    .lockout      (lockout),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = off, 1 = running, 2 = locked out
  int m_mode = 0;
  int m_cnt  = 0;
  int m_lat  = 0;
  int m_ramp = 0;

  // Results of the most recent period
  int last_duty;
  int last_highs;
  int last_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input logic [15:0] p);
    int d;
    d = -int'($signed(p));
    if (d <= 0) return 0;
    d = d / (1 << SHIFT);
    if (d > 255) d = 255;
    return d;
  endfunction

  function automatic int eff_duty();
`ifdef COMP_SOFTSTART_EN
    return (m_lat < m_ramp) ? m_lat : m_ramp;
`else
    return m_lat;
`endif
  endfunction

  function automatic void model_start(input int dn);
    m_mode = 1;
    m_lat  = dn;
    m_ramp = STEP;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_lat  = 0;
    m_ramp = 0;
  endfunction

  // Boundary decision using the inputs in force at the end of the period.
  function automatic void model_pb(input bit en_f, input logic [15:0] pid_f, input bit dropped);
    int dn;
    dn = duty_of(pid_f);
    if (m_mode == 1 && dropped) begin
      m_mode = 2;
      m_cnt  = MIN_OFF;
    end
    case (m_mode)
      0: if (en_f && dn > 0) model_start(dn);
      1: begin
        if (!en_f || dn == 0) begin
          m_mode = 2;
          m_cnt  = MIN_OFF;
        end else begin
          m_lat  = dn;
          m_ramp = (m_ramp + STEP > 255) ? 255 : m_ramp + STEP;
        end
      end
      default: begin
        if (m_cnt <= 1) begin
          m_cnt  = 0;
          m_mode = 0;
          if (en_f && dn > 0) model_start(dn);
        end else begin
          m_cnt--;
        end
      end
    endcase
  endfunction

  // One full PWM period, entered and left just after a falling edge. Inputs
  // switch to (en2, pid2) after sample chg_at (0 = no change, keep <200).
  task automatic run_period(input string name, input bit en, input logic [15:0] pid,
                            input int chg_at, input bit en2, input logic [15:0] pid2);
    int eff, highs, exp_highs, bad_samp, ps_cnt, duty_mid, lock_mid, exp_duty, exp_lock;
    bit ps_last, exp_c, dropped, en_f;
    logic [15:0] pid_f;
    eff = eff_duty();
    highs = 0; exp_highs = 0; bad_samp = 0; ps_cnt = 0;
    duty_mid = 0; lock_mid = 0; ps_last = 1'b0;
    enable  = en;
    pid_out = pid;
    for (int j = 1; j <= PLEN; j++) begin
      @(posedge clk);
      @(negedge clk);
      dropped = !en || (chg_at != 0 && !en2 && chg_at < j);
      exp_c   = (m_mode == 1) && !dropped && ((j - 1) < eff);
      if (exp_c) exp_highs++;
      if (comp_on === 1'b1) highs++;
      if (comp_on !== exp_c) bad_samp++;
      if (period_start === 1'b1) ps_cnt++;
      if (j == 200) begin
        duty_mid = int'(duty_applied);
        lock_mid = int'(lockout);
      end
      if (j == PLEN) ps_last = period_start;
      if (j == chg_at) begin
        enable  = en2;
        pid_out = pid2;
      end
    end
    dropped  = !en || (chg_at != 0 && !en2);
    exp_duty = (m_mode == 1 && !dropped) ? eff : 0;
    exp_lock = (m_mode == 2 || (m_mode == 1 && dropped)) ? 1 : 0;
    check({name, "_highs"}, highs, exp_highs);
    check({name, "_shape"}, bad_samp, 0);
    check({name, "_duty"}, duty_mid, exp_duty);
    check({name, "_lockout"}, lock_mid, exp_lock);
    check({name, "_ps_count"}, ps_cnt, 1);
    check({name, "_ps_last"}, ps_last, 1'b1);
    last_duty  = duty_mid;
    last_highs = highs;
    last_lock  = lock_mid;
    $display("period %-10s en=%0d pid=%h chg@%0d duty=%0d highs=%0d lockout=%0d",
             name, en, pid, chg_at, duty_mid, highs, lock_mid);
    en_f  = (chg_at != 0) ? en2 : en;
    pid_f = (chg_at != 0) ? pid2 : pid;
    model_pb(en_f, pid_f, dropped);
  endtask

  // Asynchronous reset pulse a few clks into a period.
  task automatic mid_reset();
    bit exp_c;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      @(negedge clk);
    end
    exp_c = (m_mode == 1) && enable && (4 < eff_duty());
    check("mreset_before_comp", comp_on, exp_c);
    #2 rst_n = 1'b0;
    #1;
    check("mreset_comp", comp_on, 1'b0);
    check("mreset_duty", duty_applied, 8'd0);
    check("mreset_lockout", lockout, 1'b0);
    check("mreset_ps", period_start, 1'b0);
    $display("async reset mid-period: comp_on=%0d duty=%0d", comp_on, duty_applied);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] rand_pid();
    int v;
    case ($urandom_range(0, 11))
      0:       return 16'h8000;
      1:       return 16'h8001;
      2:       return 16'h0000;
      3:       return 16'hFFF1;
      4:       return 16'hFFF0;
      5:       return 16'hF000;
      6:       return 16'(int'($urandom_range(1, 32767)));
      default: begin
        v = int'($urandom_range(1, 4200));
        return 16'(-v);
      end
    endcase
  endfunction

  initial begin
    int chg;
    bit en_r, en2_r;
    rst_n   = 1'b0;
    enable  = 1'b0;
    pid_out = 16'hF800;
    repeat (3) @(negedge clk);
    check("reset_comp", comp_on, 1'b0);
    check("reset_duty", duty_applied, 8'd0);
    check("reset_lockout", lockout, 1'b0);
    check("reset_ps", period_start, 1'b0);
    rst_n = 1'b1;

    // idle with enable low
    run_period("idle0", 1'b0, 16'hF800, 0, 1'b0, 16'h0);
    run_period("idle1", 1'b0, 16'hF800, 0, 1'b0, 16'h0);
    // duty 128, then full duty, then positive demand -> lockout
    run_period("start", 1'b1, 16'hF800, 0, 1'b0, 16'h0);
    run_period("d128", 1'b1, 16'hF800, 0, 1'b0, 16'h0);
`ifndef COMP_SOFTSTART_EN
    check("d128_const_duty", last_duty, 128);
    check("d128_const_highs", last_highs, 128);
`endif
    run_period("to255", 1'b1, 16'h8001, 0, 1'b0, 16'h0);
    run_period("d255", 1'b1, 16'h0100, 0, 1'b0, 16'h0);
`ifndef COMP_SOFTSTART_EN
    check("d255_const_highs", last_highs, 255);
`endif
    // lockout holds for two periods despite restored demand
    run_period("lock1", 1'b1, 16'hF800, 0, 1'b0, 16'h0);
    check("lock1_const", last_lock, 1);
    run_period("lock2", 1'b1, 16'hF800, 0, 1'b0, 16'h0);
    check("lock2_const", last_lock, 1);
    // saturation: -128.0 gives 255, -15/256 gives 0
    run_period("resume", 1'b1, 16'h8000, 0, 1'b0, 16'h0);
    run_period("sat", 1'b1, 16'hFFF1, 0, 1'b0, 16'h0);
`ifndef COMP_SOFTSTART_EN
    check("sat_const_duty", last_duty, 255);
`endif
    run_period("lock3", 1'b1, 16'hFC00, 0, 1'b0, 16'h0);
    run_period("lock4", 1'b1, 16'hFC00, 0, 1'b0, 16'h0);
    // mid-period demand change only lands at the next boundary
    run_period("mid64", 1'b1, 16'hFC00, 30, 1'b1, 16'hF400);
`ifndef COMP_SOFTSTART_EN
    check("mid64_const_duty", last_duty, 64);
`endif
    run_period("d192", 1'b1, 16'hF400, 0, 1'b0, 16'h0);
`ifndef COMP_SOFTSTART_EN
    check("d192_const_duty", last_duty, 192);
`endif
    // enable drop mid-period
    run_period("endrop", 1'b1, 16'hF400, 10, 1'b0, 16'hF400);
    check("endrop_const_highs", last_highs, 10);
    run_period("lock5", 1'b0, 16'hF800, 0, 1'b0, 16'h0);
    run_period("off", 1'b1, 16'hF800, 0, 1'b0, 16'h0);
    mid_reset();

    // randomized periods
    for (int p = 0; p < 80; p++) begin
      en_r  = ($urandom_range(0, 9) != 0);
      chg   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 199)) : 0;
      en2_r = ($urandom_range(0, 3) != 0);
      run_period($sformatf("rnd%0d", p), en_r, rand_pid(), chg, en2_r, rand_pid());
      if (p == 40) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
